// File: rtl/score_display_sched_pkg.sv
// Shared types and helpers for the score/combo/timer display controller.
//   game_state_t : top-level game FSM states
//   field_t      : display field identifiers, also the round-robin order
//   sat_add      : saturating add used by the score and combo counters
package score_display_sched_pkg;

  localparam int unsigned NUM_FIELDS = 3;
  localparam int unsigned VAL_W      = 7;
  localparam int unsigned SEG_W      = 14;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} game_state_t;
  typedef enum logic [1:0] {F_SCORE, F_COMBO, F_TIMER} field_t;

  // Sum is formed one bit wider so the ceiling compare cannot wrap.
  function automatic logic [VAL_W-1:0] sat_add(input logic [VAL_W-1:0] v,
                                               input logic [1:0]       inc,
                                               input logic [VAL_W-1:0] max_v);
    logic [VAL_W:0] sum;
    sum = {1'b0, v} + {{(VAL_W-1){1'b0}}, inc};
    if (sum > {1'b0, max_v}) begin
      return max_v;
    end
    return sum[VAL_W-1:0];
  endfunction

endpackage

// File: rtl/score_display_sched_rr_dirty_arbiter.sv
// Three-way round-robin arbiter over the display fields' dirty flags.
//   dirty    in  : one bit per field {timer, combo, score}
//   ptr      in  : field with highest priority this cycle
//   grant    out : one-hot grant, zero when nothing is dirty
//   next_ptr out : field following the granted one (ptr when no grant)
module score_display_sched_rr_dirty_arbiter
  import score_display_sched_pkg::*;
(
  input  logic [NUM_FIELDS-1:0] dirty,
  input  field_t                ptr,
  output logic [NUM_FIELDS-1:0] grant,
  output field_t                next_ptr
);

  logic [1:0] first;

  always_comb begin
    // Search order rotates so the field at ptr is looked at first.
    unique case (ptr)
      F_COMBO: first = dirty[1] ? 2'd1 : (dirty[2] ? 2'd2 : 2'd0);
      F_TIMER: first = dirty[2] ? 2'd2 : (dirty[0] ? 2'd0 : 2'd1);
      default: first = dirty[0] ? 2'd0 : (dirty[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    if (dirty != '0) begin
      grant    = 3'b001 << first;
      next_ptr = (first == 2'd2) ? F_SCORE : field_t'(first + 2'd1);
    end
  end

endmodule

// File: rtl/score_display_sched.sv
// Game-state controller for the score/combo/timer readout. Counts hit/miss events and
// timer seconds, and time-shares one external two-digit segment decoder among the three
// display fields, refreshing whichever field is dirty in round-robin order.
//   Clk, Reset_n       : clock, synchronous active-low reset
//   start, pause       : game control pulses (start wins over pause)
//   hit, miss          : note judge pulses, honoured only while running
//   dec_val / dec_seg  : shared decoder request (comb) and same-cycle result
//   score/combo/timer_seg : registered segment words
//   seg_valid          : {timer,combo,score} captured since last start/reset
//   game_over          : high while in OVER
module score_display_sched
  import score_display_sched_pkg::*;
#(
  parameter int unsigned MAX_VAL    = 89,
  parameter int unsigned TIMER_INIT = 60,
  parameter int unsigned TICK_DIV   = 50_000_000
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  hit,
  input  logic                  miss,
  output logic [VAL_W-1:0]      dec_val,
  input  logic [SEG_W-1:0]      dec_seg,
  output logic [SEG_W-1:0]      score_seg,
  output logic [SEG_W-1:0]      combo_seg,
  output logic [SEG_W-1:0]      timer_seg,
  output logic [NUM_FIELDS-1:0] seg_valid,
  output logic                  game_over
);

  localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VAL);
  localparam logic [VAL_W-1:0] INIT_V   = VAL_W'(TIMER_INIT);

  game_state_t          state_q, state_d;
  logic [VAL_W-1:0]     score_q, score_d, combo_q, combo_d, timer_q, timer_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [NUM_FIELDS-1:0] dirty_q, dirty_d, seg_valid_q, changed, grant;
  field_t               rr_q, rr_next;
  logic [SEG_W-1:0]     score_seg_q, combo_seg_q, timer_seg_q;
  logic                 game_over_q;

  score_display_sched_rr_dirty_arbiter u_arb (
    .dirty    (dirty_q),
    .ptr      (rr_q),
    .grant    (grant),
    .next_ptr (rr_next)
  );

  // Game FSM and counters.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    combo_d = combo_q;
    timer_d = timer_q;
    presc_d = presc_q;
    if (start) begin
      state_d = RUN;
      score_d = '0;
      combo_d = '0;
      timer_d = INIT_V;
      presc_d = '0;
    end else if (state_q == RUN) begin
      if (miss) begin
        combo_d = '0;
      end else if (hit) begin
        score_d = sat_add(score_q, (combo_q >= 7'd10) ? 2'd2 : 2'd1, MAX_V);
        combo_d = sat_add(combo_q, 2'd1, MAX_V);
      end
      if (presc_q == TICK_LAST) begin
        presc_d = '0;
        if (timer_q != '0) begin
          timer_d = timer_q - 7'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
      // Running out of time beats a simultaneous pause.
      if (timer_d == '0) begin
        state_d = OVER;
      end else if (pause) begin
        state_d = PAUSED;
      end
    end else if (state_q == PAUSED && pause) begin
      state_d = RUN;
    end
  end

  // A field granted this cycle stays dirty if it also changes on this edge.
  always_comb begin
    changed = {timer_d != timer_q, combo_d != combo_q, score_d != score_q};
    dirty_d = start ? 3'b111 : ((dirty_q & ~grant) | changed);
  end

  always_comb begin
    dec_val = '0;
    unique case (grant)
      3'b001:  dec_val = score_q;
      3'b010:  dec_val = combo_q;
      3'b100:  dec_val = timer_q;
      default: dec_val = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      score_q     <= '0;
      combo_q     <= '0;
      timer_q     <= INIT_V;
      presc_q     <= '0;
      dirty_q     <= 3'b111;
      rr_q        <= F_SCORE;
      score_seg_q <= '0;
      combo_seg_q <= '0;
      timer_seg_q <= '0;
      seg_valid_q <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      timer_q     <= timer_d;
      presc_q     <= presc_d;
      dirty_q     <= dirty_d;
      rr_q        <= rr_next;
      seg_valid_q <= start ? '0 : (seg_valid_q | grant);
      game_over_q <= (state_d == OVER);
      if (grant[0]) score_seg_q <= dec_seg;
      if (grant[1]) combo_seg_q <= dec_seg;
      if (grant[2]) timer_seg_q <= dec_seg;
    end
  end

  assign score_seg = score_seg_q;
  assign combo_seg = combo_seg_q;
  assign timer_seg = timer_seg_q;
  assign seg_valid = seg_valid_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_display_sched.sv
module tb_score_display_sched;

  localparam int DIV_A  = 4;
  localparam int INIT_A = 3;
  localparam int DIV_B  = 1000;
  localparam int INIT_B = 60;
  localparam int MAXV   = 89;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_OVER = 3;

  typedef struct {
    int st;
    int score;
    int combo;
    int timer;
    int presc;
  } mdl_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0, start = 1'b0, pause = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [6:0]  dec_val_a, dec_val_b;
  logic [13:0] dec_seg_a, dec_seg_b;
  logic [13:0] score_seg_a, combo_seg_a, timer_seg_a;
  logic [13:0] score_seg_b, combo_seg_b, timer_seg_b;
  logic [2:0]  seg_valid_a, seg_valid_b;
  logic        game_over_a, game_over_b;

  int   checks = 0;
  int   errors = 0;
  int   mon_prints = 0;
  bit   mon_en = 1'b0;
  mdl_t ma, mb;

  always #5 Clk = ~Clk;

  // Golden decoder: digit segments packed as {a,f,b,g,e,c,d}, leading zero blanked.
  function automatic logic [6:0] digit(input int d);
    logic [6:0] s;  // abcdefg
    case (d)
      0: s = 7'b1111110;
      1: s = 7'b0110000;
      2: s = 7'b1101101;
      3: s = 7'b1111001;
      4: s = 7'b0110011;
      5: s = 7'b1011011;
      6: s = 7'b1011111;
      7: s = 7'b1110000;
      8: s = 7'b1111111;
      default: s = 7'b1111011;
    endcase
    return {s[6], s[1], s[5], s[0], s[2], s[4], s[3]};
  endfunction

  function automatic logic [13:0] decode(input int v);
    return {(v / 10 == 0) ? 7'b0 : digit(v / 10), digit(v % 10)};
  endfunction

  assign dec_seg_a = decode(int'(dec_val_a));
  assign dec_seg_b = decode(int'(dec_val_b));

  score_display_sched #(.MAX_VAL(MAXV), .TIMER_INIT(INIT_A), .TICK_DIV(DIV_A)) u_dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .pause(pause), .hit(hit), .miss(miss),
    .dec_val(dec_val_a), .dec_seg(dec_seg_a), .score_seg(score_seg_a),
    .combo_seg(combo_seg_a), .timer_seg(timer_seg_a), .seg_valid(seg_valid_a),
    .game_over(game_over_a)
  );

  score_display_sched #(.MAX_VAL(MAXV), .TIMER_INIT(INIT_B), .TICK_DIV(DIV_B)) u_dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .pause(pause), .hit(hit), .miss(miss),
    .dec_val(dec_val_b), .dec_seg(dec_seg_b), .score_seg(score_seg_b),
    .combo_seg(combo_seg_b), .timer_seg(timer_seg_b), .seg_valid(seg_valid_b),
    .game_over(game_over_b)
  );

  // Reference model of the game rules, one call per clock edge.
  function automatic mdl_t step(input mdl_t m, input bit rn, input bit s, input bit p,
                                input bit h, input bit mi, input int div, input int init);
    mdl_t n = m;
    if (!rn) begin
      n.st = M_IDLE; n.score = 0; n.combo = 0; n.timer = init; n.presc = 0;
    end else if (s) begin
      n.st = M_RUN; n.score = 0; n.combo = 0; n.timer = init; n.presc = 0;
    end else if (m.st == M_RUN) begin
      if (mi) begin
        n.combo = 0;
      end else if (h) begin
        n.score = m.score + ((m.combo >= 10) ? 2 : 1);
        if (n.score > MAXV) n.score = MAXV;
        n.combo = (m.combo + 1 > MAXV) ? MAXV : m.combo + 1;
      end
      n.presc = m.presc + 1;
      if (n.presc == div) begin
        n.presc = 0;
        n.timer = m.timer - 1;
      end
      if (n.timer == 0) n.st = M_OVER;
      else if (p) n.st = M_PAUSED;
    end else if (m.st == M_PAUSED && p) begin
      n.st = M_RUN;
    end
    return n;
  endfunction

  task automatic cyc(input bit rn, input bit s, input bit p, input bit h, input bit m);
    Reset_n = rn; start = s; pause = p; hit = h; miss = m;
    @(posedge Clk);
    ma = step(ma, rn, s, p, h, m, DIV_A, INIT_A);
    mb = step(mb, rn, s, p, h, m, DIV_B, INIT_B);
    #1;
    Reset_n = 1'b1; start = 1'b0; pause = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Continuous checks: decoder range and game_over against the model.
  always @(negedge Clk) begin
    if (mon_en && Reset_n === 1'b1) begin
      checks++;
      if (dec_val_a > 7'd89 || dec_val_b > 7'd89 ||
          game_over_a !== (ma.st == M_OVER) || game_over_b !== (mb.st == M_OVER)) begin
        errors++;
        if (mon_prints < 10) begin
          mon_prints++;
          $display("FAIL monitor: dec_val a=%0d b=%0d game_over a=%b b=%b required <=89, %b %b",
                   dec_val_a, dec_val_b, game_over_a, game_over_b,
                   ma.st == M_OVER, mb.st == M_OVER);
        end
      end
    end
  end

  task automatic test_reset;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (score_seg_a !== 14'd0 || timer_seg_a !== 14'd0 || seg_valid_a !== 3'b000 ||
        game_over_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: score=%h timer=%h valid=%b over=%b required 0", score_seg_a,
               timer_seg_a, seg_valid_a, game_over_a);
    end
    mon_en = 1'b1;
    idle(1);
    checks++;
    if (seg_valid_a !== 3'b001) begin
      errors++;
      $display("FAIL reset_first_capture: valid=%b required 001", seg_valid_a);
    end
    idle(2);
    checks++;
    if (score_seg_a !== 14'b00000001110111 || combo_seg_a !== 14'b00000001110111 ||
        timer_seg_a !== 14'b00000001011011 || seg_valid_a !== 3'b111) begin
      errors++;
      $display("FAIL reset_refresh: score=%b combo=%b timer=%b valid=%b", score_seg_a,
               combo_seg_a, timer_seg_a, seg_valid_a);
    end
    checks++;
    if (timer_seg_b !== decode(INIT_B) || seg_valid_b !== 3'b111) begin
      errors++;
      $display("FAIL reset_timer_b: got %h/%b required %h/111", timer_seg_b, seg_valid_b,
               decode(INIT_B));
    end
    // Idle must ignore hits.
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (score_seg_a !== decode(ma.score) || combo_seg_a !== 14'b00000001110111) begin
      errors++;
      $display("FAIL idle_hits: score=%h combo=%h required %h", score_seg_a, combo_seg_a,
               decode(ma.score));
    end
  endtask

  task automatic test_hits;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (score_seg_b !== 14'b00100100111010 || score_seg_b !== decode(mb.score)) begin
      errors++;
      $display("FAIL hits_score: got %b required %b", score_seg_b, decode(mb.score));
    end
    checks++;
    if (combo_seg_b !== decode(12) || seg_valid_b !== 3'b111) begin
      errors++;
      $display("FAIL hits_combo: got %h/%b required %h/111", combo_seg_b, seg_valid_b,
               decode(12));
    end
  endtask

  task automatic test_saturate;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (60) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (score_seg_b !== decode(89) || combo_seg_b !== decode(60)) begin
      errors++;
      $display("FAIL saturate: score=%h combo=%h required %h %h", score_seg_b, combo_seg_b,
               decode(89), decode(60));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (score_seg_b !== decode(mb.score) || combo_seg_b !== decode(0)) begin
      errors++;
      $display("FAIL saturate_miss: score=%h combo=%h required %h %h", score_seg_b,
               combo_seg_b, decode(mb.score), decode(0));
    end
  endtask

  task automatic test_hit_miss;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (combo_seg_b !== decode(0) || score_seg_b !== decode(5) ||
        combo_seg_a !== decode(ma.combo) || score_seg_a !== decode(ma.score)) begin
      errors++;
      $display("FAIL hit_and_miss: b=%h/%h a=%h/%h required combo %h score %h", combo_seg_b,
               score_seg_b, combo_seg_a, score_seg_a, decode(0), decode(5));
    end
  endtask

  task automatic test_timer;
    int n;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (game_over_a !== 1'b1 && n < 40) begin
      idle(1);
      n++;
    end
    checks++;
    if (n != DIV_A * INIT_A) begin
      errors++;
      $display("FAIL timer_run_len: got %0d cycles required %0d", n, DIV_A * INIT_A);
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (timer_seg_a !== decode(0) || score_seg_a !== decode(ma.score)) begin
      errors++;
      $display("FAIL over_ignores_hits: timer=%h score=%h required %h %h", timer_seg_a,
               score_seg_a, decode(0), decode(ma.score));
    end
    // Pause after 7 running edges (the pause edge itself still counts).
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    checks++;
    if (timer_seg_a !== decode(ma.timer) || timer_seg_a !== decode(2) || game_over_a !== 1'b0)
    begin
      errors++;
      $display("FAIL pause_hold: timer=%h over=%b required %h 0", timer_seg_a, game_over_a,
               decode(2));
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (game_over_a !== 1'b1 && n < 40) begin
      idle(1);
      n++;
    end
    checks++;
    if (n != DIV_A * INIT_A - 7) begin
      errors++;
      $display("FAIL resume_len: got %0d cycles required %0d", n, DIV_A * INIT_A - 7);
    end
  endtask

  task automatic test_random;
    int r;
    int pre_st;
    bit p, h, m;
    for (int it = 0; it < 4; it++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) begin
        r = int'($urandom_range(0, 9));
        h = (r < 6);
        m = (r == 6) || (r == 7 && h == 1'b0 && $urandom_range(0, 1) == 1);
        p = ($urandom_range(0, 14) == 0);
        cyc(1'b1, 1'b0, p, h, m);
      end
      pre_st = ma.st;
      idle(3);
      checks++;
      if (score_seg_b !== decode(mb.score) || combo_seg_b !== decode(mb.combo) ||
          timer_seg_b !== decode(mb.timer) || seg_valid_b !== 3'b111) begin
        errors++;
        $display("FAIL random_b[%0d]: %h %h %h %b required %h %h %h 111", it, score_seg_b,
                 combo_seg_b, timer_seg_b, seg_valid_b, decode(mb.score), decode(mb.combo),
                 decode(mb.timer));
      end
      checks++;
      if (score_seg_a !== decode(ma.score) || combo_seg_a !== decode(ma.combo) ||
          (pre_st != M_RUN && timer_seg_a !== decode(ma.timer))) begin
        errors++;
        $display("FAIL random_a[%0d]: %h %h %h required %h %h %h", it, score_seg_a,
                 combo_seg_a, timer_seg_a, decode(ma.score), decode(ma.combo),
                 decode(ma.timer));
      end
    end
  endtask

  task automatic test_burst_reset;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (score_seg_a !== decode(ma.score) || score_seg_b !== decode(5) ||
        combo_seg_b !== decode(5)) begin
      errors++;
      $display("FAIL burst_latency: a=%h b=%h/%h required %h %h", score_seg_a, score_seg_b,
               combo_seg_b, decode(ma.score), decode(5));
    end
    idle(6);
    checks++;
    if (game_over_a !== 1'b1) begin
      errors++;
      $display("FAIL burst_over: got %b required 1", game_over_a);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (score_seg_a !== 14'd0 || combo_seg_a !== 14'd0 || timer_seg_a !== 14'd0 ||
        seg_valid_a !== 3'b000 || game_over_a !== 1'b0 || score_seg_b !== 14'd0 ||
        seg_valid_b !== 3'b000) begin
      errors++;
      $display("FAIL midrun_reset: %h %h %h %b %b b=%h %b required all 0", score_seg_a,
               combo_seg_a, timer_seg_a, seg_valid_a, game_over_a, score_seg_b, seg_valid_b);
    end
    idle(3);
    checks++;
    if (timer_seg_a !== 14'b00000001011011 || score_seg_b !== decode(0)) begin
      errors++;
      $display("FAIL post_reset_refresh: timer=%b score_b=%h", timer_seg_a, score_seg_b);
    end
  endtask

  initial begin
    ma = '{st: M_IDLE, score: 0, combo: 0, timer: INIT_A, presc: 0};
    mb = '{st: M_IDLE, score: 0, combo: 0, timer: INIT_B, presc: 0};
    test_reset();
    test_hits();
    test_saturate();
    test_hit_miss();
    test_timer();
    test_random();
    test_burst_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
